// File: rtl/touch_sense_if.sv
// Bus bundle between the CPU address decoder and the touch_sense core.
interface touch_sense_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output cs, we, address, write_data, input read_data, ready);
  modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/touch_sense.sv
// Touch pad core: synchroniser, debounce FSM, latched event, saturating event counter, MMIO regs.
// Optional cycle-stamp of each event behind TOUCH_SENSE_TIMESTAMP_EN.
module touch_sense #(
  parameter logic [15:0] DEBOUNCE_DEFAULT = 16'd1000,
  parameter logic [31:0] CORE_VERSION     = 32'h00000001
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         touch_event,
  touch_sense_if.slave bus
);
  localparam logic [7:0] A_NAME0     = 8'h00;
  localparam logic [7:0] A_NAME1     = 8'h01;
  localparam logic [7:0] A_VERSION   = 8'h02;
  localparam logic [7:0] A_STATUS    = 8'h09;
  localparam logic [7:0] A_DEBOUNCE  = 8'h0a;
  localparam logic [7:0] A_COUNT     = 8'h0b;
  localparam logic [7:0] A_COUNT_CLR = 8'h0c;
  localparam logic [7:0] A_TIMESTAMP = 8'h0d;

  typedef enum logic [1:0] {IDLE, DEBOUNCE_ST, EVENT, WAIT_RELEASE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  sync_pipe;
  logic        sync_touch;
  logic [15:0] dcnt, dcnt_nxt;
  logic [15:0] debounce;
  logic [15:0] count;
  logic        event_flag;
  logic        fire;
  logic        access, wr;
  logic        wr_status, wr_debounce, wr_count_clr;
  logic [31:0] rdata_mux;
  logic        unused_wdata;

  assign unused_wdata = ^bus.write_data[31:16];

  // Two-flop synchroniser; sync_touch lags touch_event by two cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[0], touch_event};
  end
  assign sync_touch = sync_pipe[1];

  // A new access is any cycle with cs high that is not already being acknowledged.
  assign access       = bus.cs & ~bus.ready;
  assign wr           = access & bus.we;
  assign wr_status    = wr && (bus.address == A_STATUS);
  assign wr_debounce  = wr && (bus.address == A_DEBOUNCE);
  assign wr_count_clr = wr && (bus.address == A_COUNT_CLR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        dcnt_nxt = '0;
        if (sync_touch) state_nxt = DEBOUNCE_ST;
      end
      DEBOUNCE_ST: begin
        if (!sync_touch) begin
          dcnt_nxt  = '0;
          state_nxt = IDLE;
        // >= rather than == so a DEBOUNCE lowered mid-count fires at once
        end else if (({1'b0, dcnt} + 17'd1) >= {1'b0, debounce}) begin
          fire      = 1'b1;
          dcnt_nxt  = '0;
          state_nxt = EVENT;
        end else begin
          dcnt_nxt = dcnt + 16'd1;
        end
      end
      EVENT: ;
      WAIT_RELEASE: begin
        if (!sync_touch) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Acknowledge loses to an event setting in the same cycle.
    if (wr_status && !fire) begin
      state_nxt = WAIT_RELEASE;
      dcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          event_flag <= 1'b0;
    else if (fire)      event_flag <= 1'b1;
    else if (wr_status) event_flag <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          count <= '0;
    else if (wr_count_clr)              count <= '0;
    else if (fire && count != 16'hffff) count <= count + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            debounce <= DEBOUNCE_DEFAULT;
    else if (wr_debounce) debounce <= (bus.write_data[15:0] == 16'd0) ? 16'd1 : bus.write_data[15:0];
  end

`ifdef TOUCH_SENSE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] timestamp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt    <= '0;
      timestamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (fire) timestamp <= ts_cnt;
    end
  end
`endif

  always_comb begin
    rdata_mux = 32'h0;
    case (bus.address)
      A_NAME0:     rdata_mux = 32'h746b7365;
      A_NAME1:     rdata_mux = 32'h6e736520;
      A_VERSION:   rdata_mux = CORE_VERSION;
      A_STATUS:    rdata_mux = {31'h0, event_flag};
      A_DEBOUNCE:  rdata_mux = {16'h0, debounce};
      A_COUNT:     rdata_mux = {16'h0, count};
`ifdef TOUCH_SENSE_TIMESTAMP_EN
      A_TIMESTAMP: rdata_mux = timestamp;
`else
      A_TIMESTAMP: rdata_mux = 32'h0;
`endif
      default:     rdata_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ready     <= 1'b0;
      bus.read_data <= '0;
    end else begin
      bus.ready <= access;
      if (access) bus.read_data <= rdata_mux;
    end
  end
endmodule
